// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Brief    : Multi-cycle signed Booth multiply / restoring divide into Z pair
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int c_cnt_w = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_cnt_w-1:0] r_count;
  logic               r_op;
  logic               r_dz;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_booth;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH:0]   r_acc;

  logic               w_last;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH:0]     w_m_ext;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH:0]   w_acc_step;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo_signed;
  logic [WIDTH-1:0]   w_rem_signed;

  assign w_last   = (r_count == c_cnt_w'(WIDTH-1));
  assign w_b_zero = (operand_b == '0);
  assign w_abs_a  = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign w_abs_b  = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign w_hi     = r_acc[2*WIDTH:WIDTH];
  assign w_lo     = r_acc[WIDTH-1:0];
  assign busy     = (r_state != S_IDLE);

  assign w_quo        = r_acc[WIDTH-1:0];
  assign w_rem        = r_acc[2*WIDTH-1:WIDTH];
  assign w_quo_signed = (r_sign_a ^ r_sign_b) ? -w_quo : w_quo;
  assign w_rem_signed = r_sign_a ? -w_rem : w_rem;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_RUN;
      S_RUN:    if (w_last) w_state_next = S_FINISH;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // One iteration: upper field is one bit wider than the operands so that the
  // Booth add/sub of -2^(W-1) and the restoring trial subtract never overflow.
  always_comb begin
    w_m_ext    = '0;
    w_sum      = w_hi;
    w_trial    = '0;
    w_diff     = '0;
    w_acc_step = r_acc;
    if (!r_op) begin
      w_m_ext = {r_m[WIDTH-1], r_m};
      case ({w_lo[0], r_booth})
        2'b01:   w_sum = w_hi + w_m_ext;
        2'b10:   w_sum = w_hi - w_m_ext;
        default: w_sum = w_hi;
      endcase
      w_acc_step = {w_sum[WIDTH], w_sum, w_lo[WIDTH-1:1]};
    end else begin
      w_m_ext = {1'b0, r_m};
      w_trial = {w_hi[WIDTH-1:0], w_lo[WIDTH-1]};
      w_diff  = w_trial - w_m_ext;
      if (!w_diff[WIDTH]) begin
        w_acc_step = {w_diff, w_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_step = {w_trial, w_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_count     <= '0;
      r_op        <= 1'b0;
      r_dz        <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_booth     <= 1'b0;
      r_m         <= '0;
      r_acc       <= '0;
      z_high      <= '0;
      z_low       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_dz     <= op & w_b_zero;
            r_sign_a <= operand_a[WIDTH-1];
            r_sign_b <= operand_b[WIDTH-1];
            r_booth  <= 1'b0;
            r_acc    <= {{(WIDTH+1){1'b0}}, (op ? w_abs_a : operand_b)};
            // Divide-by-zero spends only its last RUN cycle, so its result
            // lands two edges after the start edge.
            if (op && w_b_zero) begin
              r_count <= c_cnt_w'(WIDTH-1);
              r_m     <= operand_a;
            end else begin
              r_count <= '0;
              r_m     <= op ? w_abs_b : operand_a;
            end
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_step;
          r_booth <= w_lo[0];
          r_count <= w_last ? '0 : r_count + 1'b1;
        end
        S_FINISH: begin
          done <= 1'b1;
          if (r_dz) begin
            z_low       <= '1;
            z_high      <= r_m;
            div_by_zero <= 1'b1;
          end else if (r_op) begin
            z_low       <= w_quo_signed;
            z_high      <= w_rem_signed;
            div_by_zero <= 1'b0;
          end else begin
            z_low       <= r_acc[WIDTH-1:0];
            z_high      <= r_acc[2*WIDTH-1:WIDTH];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Directed + random checks of mul_div_unit against a reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] z_high;
  logic [31:0] z_low;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .z_high      (z_high),
    .z_low       (z_low),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the operand values.
  function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz);
    longint p;
    int     sa;
    int     sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    if (!o) begin
      p = longint'(sa) * longint'(sb);
      {hi, lo} = p;
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
      dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 32'd0;
    end else begin
      lo = sa / sb;
      hi = sa % sb;
    end
  endfunction

  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble);
    logic [31:0] eh;
    logic [31:0] el;
    logic        ed;
    int          lat;
    int          exp_lat;
    bit          busy_ok;
    model(o, a, b, eh, el, ed);
    exp_lat = (o && b == 32'd0) ? 2 : 33;
    @(negedge clock);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (!busy) busy_ok = 1'b0;
      op        = 1'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
      start     = (scramble && k == 10);
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_held", {63'd0, busy_ok}, 64'd1);
    chk("busy_low_at_done", {63'd0, busy}, 64'd0);
    chk("z_pair", {z_high, z_low}, {eh, el});
    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, ed});
    @(posedge clock);
    #1;
    chk("done_single", {63'd0, done}, 64'd0);
    chk("z_hold", {z_high, z_low}, {eh, el});
  endtask

  initial begin
    bit          seen_done;
    int          d1;
    int          d2;
    logic [31:0] eh;
    logic [31:0] el;
    logic        ed;

    clear     = 1'b1;
    start     = 1'b0;
    op        = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_z", {z_high, z_low}, 64'd0);
    chk("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(negedge clock);
    clear = 1'b0;

    run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(1'b1, 32'd100,       32'hFFFF_FFF9, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'd55,        32'd0,         1'b0);
    run_op(1'b0, 32'd2,         32'd3,         1'b0);
    run_op(1'b0, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);

    // Clear in the middle of a multiply: immediate zeros, no done afterwards.
    @(negedge clock);
    op        = 1'b0;
    operand_a = 32'd5;
    operand_b = 32'd9;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    chk("clear_z", {z_high, z_low}, 64'd0);
    chk("clear_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(negedge clock);
    clear     = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("no_done_after_clear", {63'd0, seen_done}, 64'd0);
    run_op(1'b0, 32'd5, 32'd9, 1'b0);

    // Start held high: back-to-back ops, the second accepted in the done cycle.
    @(negedge clock);
    op        = 1'b1;
    operand_a = 32'hFFFF_FC00;
    operand_b = 32'd33;
    start     = 1'b1;
    model(1'b1, 32'hFFFF_FC00, 32'd33, eh, el, ed);
    d1 = -1;
    d2 = -1;
    for (int e = 0; e <= 80; e++) begin
      @(posedge clock);
      #1;
      if (done) begin
        if (d1 < 0) d1 = e;
        else begin
          d2 = e;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    chk("held_first_done", 64'(d1), 64'd33);
    chk("held_second_done", 64'(d2), 64'd67);
    chk("held_z", {z_high, z_low}, {eh, el});

    for (int i = 0; i < 20; i++) begin
      logic        ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($signed(4'($urandom)));
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op(ro, ra, rb, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
